cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Arbitrates N execution-unit result producers onto the single common data bus (CDB).
//   The CDB drives the register file write port (enWrt/wrtName/wrtData/wrtTag) and the
//   reservation-station tag snoop. Grants at most one producer per cycle, fair round-robin.
//   Output is registered, so the register file always sees a clean, single-cycle write pulse.
// PARAMETERS
//   N_REQ   4   number of producers (ALU0, ALU1, LSU, BRU); 2..8
//   DATA_W  32  result width, equals DataBus width
//   NAME_W  5   architectural register name width, equals NameBus width
//   TAG_W   4   rename tag width, equals TagBus width
// PORTS
//   clk        in   1              clock
//   rst        in   1              reset; synchronous, active-high
//   flush      in   1              pipeline flush (mispredict): drop all pending broadcasts
//   req_valid  in   N_REQ          producer i holds a result
//   req_ready  out  N_REQ          one-hot grant; transfer when req_valid[i] & req_ready[i]
//   req_name   in   N_REQ*NAME_W   destination register per producer, packed, i at [i*W +: W]
//   req_data   in   N_REQ*DATA_W   result value per producer
//   req_tag    in   N_REQ*TAG_W    rename tag per producer
//   cdb_valid  out  1              broadcast valid; drives regfile enWrt
//   cdb_name   out  NAME_W         drives wrtName
//   cdb_data   out  DATA_W         drives wrtData
//   cdb_tag    out  TAG_W          drives wrtTag and RS tag compare
//   cdb_src    out  $clog2(N_REQ)  index of the producer that won; debug and performance counters
// BEHAVIOUR
//   - Reset: cdb_valid=0, cdb_name=0, cdb_data=0, cdb_tag=`tagFree, cdb_src=0, rr_ptr=0.
//     req_ready=0 while rst is high.
//   - req_ready is combinational from req_valid, rr_ptr and flush.
//   - Winner: the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   - req_ready is one-hot on the winner and all-zero when no request is valid.
//   - Latency: winner sampled at edge t; cdb_* valid for exactly one cycle after edge t.
//   - One grant per cycle. A producer must hold valid, name, data and tag stable until granted.
//     Dropping valid before the grant is illegal. Bench asserts on it.
//   - rr_ptr update: only on a grant, to winner+1, wrapping at N_REQ-1 -> 0. Otherwise it holds.
//   - Back-to-back: the same producer may win on consecutive cycles only when it is the sole
//     requester.
//   - Name 0: broadcast as normal. The regfile discards the data, but the RS still needs the tag.
//   - flush high in cycle t:
//     - req_ready forced to 0;
//     - cdb_valid=0 after edge t, and any registered broadcast is dropped;
//     - rr_ptr holds.
//   - flush and rst at the same time: rst wins.
//   - No back-pressure from the regfile. It accepts one write every cycle.
//   - Idle cycle: cdb_valid=0; cdb_name, cdb_data and cdb_tag hold their last values.
//     Consumers qualify on cdb_valid.
// STRUCTURE
//   - Shared defines header: DataBus, NameBus, TagBus, `tagFree, `regSize.
//     Add CdbSrcBus and `cdbReqNum there.
//   - Sub-module rr_pick (combinational): inputs req[N] and ptr; outputs one-hot gnt[N],
//     gnt_idx and any. Reusable for the issue-port arbiters.
//   - Top level: rr_pick, output register, rr_ptr register, and a packed-bus mux indexed by gnt_idx.
// TESTING
//   1. Reset: assert rst 2 cycles with req_valid=4'b1111 -> req_ready=0, cdb_valid=0,
//      cdb_tag=`tagFree.
//   2. Single producer: req_valid=4'b0100, name=7, data=32'hDEADBEEF, tag=3 ->
//      req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_name=7,
//      cdb_data=DEADBEEF, cdb_tag=3, cdb_src=2.
//   3. Fairness: all 4 requesting continuously from rr_ptr=0 -> grant order 0,1,2,3,0.
//      No producer waits more than 4 cycles.
//   4. Wrap: rr_ptr=3, req_valid=4'b1001 -> producer 3 wins, rr_ptr=0, then producer 0 wins.
//   5. Flush: producer 1 granted at t, flush at t+1 -> cdb_valid=0 at t+2.
//      Mid-wait flush: req_valid=4'b0011, flush at t -> req_ready=0 at t, cdb_valid=0 at t+1,
//      rr_ptr unchanged.
//   6. Regfile end-to-end: broadcast name=0, tag=5 -> regfile x0 stays 0; RS entry waiting
//      on tag 5 wakes next cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB bus types and constants.
// Widths match the register file and reservation-station buses.
package cdb_arbiter_pkg;

  localparam int CDB_REQ_NUM = 4;
  localparam int DATA_BUS_W  = 32;
  localparam int NAME_BUS_W  = 5;
  localparam int TAG_BUS_W   = 4;
  localparam int REG_SIZE    = 32;
  localparam int CDB_SRC_W   = $clog2(CDB_REQ_NUM);

  // Tag value meaning "no producer pending".
  localparam logic [TAG_BUS_W-1:0] TAG_FREE = '1;

  typedef logic [DATA_BUS_W-1:0] data_bus_t;
  typedef logic [NAME_BUS_W-1:0] name_bus_t;
  typedef logic [TAG_BUS_W-1:0]  tag_bus_t;
  typedef logic [CDB_SRC_W-1:0]  cdb_src_bus_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker.
// First set request at or after ptr_i, modulo N.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  int j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    // Walk from furthest to nearest so the nearest hit lands last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        gnt_idx_o = W'(j);
        any_o     = 1'b1;
      end
    end
    if (any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of producer results onto the common data bus.
// Broadcast is registered: one clean write pulse per grant.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_REQ  = CDB_REQ_NUM,
  parameter  int DATA_W = DATA_BUS_W,
  parameter  int NAME_W = NAME_BUS_W,
  parameter  int TAG_W  = TAG_BUS_W,
  localparam int SRC_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*NAME_W-1:0] req_name,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic                cdb_valid,
  output logic [NAME_W-1:0]   cdb_name,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [SRC_W-1:0]    cdb_src
);

  localparam logic [TAG_W-1:0] TagFree =
    TAG_W'(TAG_FREE);

  logic [N_REQ-1:0]  live;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;

  logic              cdb_valid_q;
  logic [NAME_W-1:0] name_q, name_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [SRC_W-1:0]  src_q;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Masking requests makes the picker grant nothing on rst/flush.
  assign live = (rst || flush) ? '0 : req_valid;

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i     (live),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    name_d   = req_name[int'(gnt_idx)*NAME_W +: NAME_W];
    data_d   = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    tag_d    = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
    rr_ptr_d = SRC_W'(rr_next(int'(gnt_idx), N_REQ));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      name_q      <= '0;
      data_q      <= '0;
      tag_q       <= TagFree;
      src_q       <= '0;
      rr_ptr_q    <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= gnt_any;
      if (gnt_any) begin
        name_q   <= name_d;
        data_q   <= data_d;
        tag_q    <= tag_d;
        src_q    <= gnt_idx;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_name  = name_q;
  assign cdb_data  = data_q;
  assign cdb_tag   = tag_q;
  assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter.
// Reference model: round-robin search over producer table.
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam logic [3:0] TFREE = 4'hF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   req_valid, req_ready;
  logic [19:0]  req_name;
  logic [127:0] req_data;
  logic [15:0]  req_tag;
  logic         cdb_valid;
  logic [4:0]   cdb_name;
  logic [31:0]  cdb_data;
  logic [3:0]   cdb_tag;
  logic [1:0]   cdb_src;

  bit          v[N];
  logic [4:0]  nm[N];
  logic [31:0] dt[N];
  logic [3:0]  tg[N];

  int          m_ptr;
  bit          e_valid;
  logic [4:0]  e_name;
  logic [31:0] e_data;
  logic [3:0]  e_tag;
  int          e_src;
  int          last_g;
  int          wt[N];
  int          max_wt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_name  = '0;
    req_data  = '0;
    req_tag   = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = v[i];
      req_name[i*5 +: 5] = nm[i];
      req_data[i*32 +: 32] = dt[i];
      req_tag[i*4 +: 4]  = tg[i];
    end
  end

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_name  (req_name),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .cdb_valid (cdb_valid),
    .cdb_name  (cdb_name),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src)
  );

  task automatic load(input int i, input logic [4:0] n,
                      input logic [31:0] d, input logic [3:0] t);
    v[i] = 1'b1; nm[i] = n; dt[i] = d; tg[i] = t;
  endtask

  task automatic load_rand(input int i);
    load(i, 5'($urandom), $urandom, 4'($urandom_range(14)));
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  task automatic retire();
    if (last_g >= 0) v[last_g] = 1'b0;
  endtask

  // One clock: check ready mid-cycle, then broadcast after the edge.
  task automatic cycle(input bit fl);
    int g;
    logic [3:0] er;
    flush = fl;
    @(negedge clk);
    g = -1;
    if (!fl)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (v[i] && g < 0) g = i;
      end
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL req_ready: got %b want %b", req_ready, er);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] || !v[i]) wt[i] = 0;
      else wt[i]++;
      if (wt[i] > max_wt) max_wt = wt[i];
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (fl) e_valid = 1'b0;
    else if (g >= 0) begin
      e_valid = 1'b1;
      e_name  = nm[g];
      e_data  = dt[g];
      e_tag   = tg[g];
      e_src   = g;
      m_ptr   = (g + 1) % N;
    end else e_valid = 1'b0;
    last_g = g;
    checks++;
    if (cdb_valid !== e_valid) begin
      errors++;
      $display("FAIL cdb_valid: got %b want %b", cdb_valid, e_valid);
    end
    checks++;
    if ({cdb_name, cdb_data, cdb_tag} !== {e_name, e_data, e_tag}) begin
      errors++;
      $display("FAIL cdb_fields: got %h/%h/%h want %h/%h/%h",
               cdb_name, cdb_data, cdb_tag, e_name, e_data, e_tag);
    end
    if (e_valid) begin
      checks++;
      if (cdb_src !== 2'(e_src)) begin
        errors++;
        $display("FAIL cdb_src: got %0d want %0d", cdb_src, e_src);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) load_rand(i);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cdb_valid, cdb_name, cdb_data, cdb_tag, cdb_src} !==
          {1'b0, 5'd0, 32'd0, TFREE, 2'd0}) begin
        errors++;
        $display("FAIL reset_cdb: got v=%b n=%h d=%h t=%h s=%0d want 0/0/0/f/0",
                 cdb_valid, cdb_name, cdb_data, cdb_tag, cdb_src);
      end
    end
    rst = 1'b0;
    clear_all();
    m_ptr = 0; e_valid = 1'b0; e_name = '0;
    e_data = '0; e_tag = TFREE; e_src = 0;
    last_g = -1;
    max_wt = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
  endtask

  task automatic test_single();
    load(2, 5'd7, 32'hDEADBEEF, 4'd3);
    cycle(1'b0);
    checks++;
    if ({cdb_valid, cdb_name, cdb_data, cdb_tag, cdb_src} !==
        {1'b1, 5'd7, 32'hDEADBEEF, 4'd3, 2'd2}) begin
      errors++;
      $display("FAIL single: got v=%b n=%0d d=%h t=%0d s=%0d", cdb_valid,
               cdb_name, cdb_data, cdb_tag, cdb_src);
    end
    retire();
    cycle(1'b0);
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    test_reset();
    for (int i = 0; i < N; i++) load_rand(i);
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0);
      if (c < 5) begin
        checks++;
        if (cdb_src !== 2'(order[c])) begin
          errors++;
          $display("FAIL fair_order[%0d]: got %0d want %0d", c, cdb_src, order[c]);
        end
      end
      if (last_g >= 0) load_rand(last_g);
    end
    checks++;
    if (max_wt >= N) begin
      errors++;
      $display("FAIL fair_wait: got %0d want < %0d", max_wt, N);
    end
    clear_all();
  endtask

  task automatic test_wrap();
    test_reset();
    load_rand(2);
    cycle(1'b0);
    retire();
    load_rand(0);
    load_rand(3);
    cycle(1'b0);
    checks++;
    if (cdb_src !== 2'd3) begin
      errors++;
      $display("FAIL wrap_first: got %0d want 3", cdb_src);
    end
    retire();
    cycle(1'b0);
    checks++;
    if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_second: got %0d/%b want 0/1", cdb_src, cdb_valid);
    end
    retire();
  endtask

  task automatic test_flush();
    test_reset();
    load_rand(1);
    cycle(1'b0);
    retire();
    cycle(1'b1);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got %b want 0", cdb_valid);
    end
    load_rand(0);
    load_rand(1);
    cycle(1'b1);
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_midwait: got %b want 0", cdb_valid);
    end
    cycle(1'b0);
    checks++;
    if (cdb_src !== 2'd0) begin
      errors++;
      $display("FAIL flush_ptr: got %0d want 0", cdb_src);
    end
    retire();
    cycle(1'b0);
    retire();
  endtask

  task automatic test_regfile();
    logic [31:0] rf[32];
    bit rs_wait;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rs_wait = 1'b1;
    load(3, 5'd0, 32'hCAFE0001, 4'd5);
    cycle(1'b0);
    if (cdb_valid && cdb_name != 5'd0) rf[cdb_name] = cdb_data;
    if (cdb_valid && cdb_tag == 4'd5) rs_wait = 1'b0;
    retire();
    checks++;
    if (rf[0] !== 32'd0 || rs_wait !== 1'b0) begin
      errors++;
      $display("FAIL regfile_x0: got x0=%h wait=%b want 0/0", rf[0], rs_wait);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(1) == 1) load_rand(i);
      cycle($urandom_range(9) == 0);
      retire();
    end
    clear_all();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_flush();
    test_regfile();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
